// File: rtl/udt_pkg.sv
// Shared UDT control-plane definitions: control type codes, dispatch routes,
// dispatcher FSM states and the beat-0 route decoder.
package udt_pkg;

    localparam logic [14:0] CT_ACK   = 15'd2;
    localparam logic [14:0] CT_NAK   = 15'd3;
    localparam logic [14:0] CT_ACK2  = 15'd6;
    localparam int          N_ROUTES = 5;

    typedef enum logic [2:0] {
        R_NAK  = 3'd0,
        R_ACK  = 3'd1,
        R_ACK2 = 3'd2,
        R_MISC = 3'd3,
        R_DROP = 3'd4
    } route_e;

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_FWD  = 2'd1,
        S_DROP = 2'd2
    } state_e;

    // Header must carry the control flag, be a full 8-byte beat and not end the
    // packet; anything shorter than 16 bytes cannot hold a UDT control header.
    function automatic route_e decode_route(input logic [63:0] tdata,
                                            input logic [7:0]  tkeep,
                                            input logic        tlast);
        route_e r;
        if (!tdata[63] || tlast || (tkeep != 8'hFF)) begin
            r = R_DROP;
        end else begin
            case (tdata[62:48])
                CT_NAK:  r = R_NAK;
                CT_ACK:  r = R_ACK;
                CT_ACK2: r = R_ACK2;
                default: r = R_MISC;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/ctrl_dispatch_if.sv
// 64-bit AXI4-Stream link used for the inbound control stream and every
// dispatch output of ctrl_dispatch.
interface ctrl_dispatch_if;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tvalid;
    logic        tlast;
    logic        tready;

    modport master (output tdata, output tkeep, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tkeep, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/ctrl_dispatch.sv
// UDT control-packet dispatcher: routes each inbound packet by its header type
// to NAK/ACK/ACK2/MISC with zero latency, drops non-control and malformed ones.
module ctrl_dispatch
    import udt_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                core_clk,
    input  logic                core_rst,
    ctrl_dispatch_if.slave      ctrl,
    ctrl_dispatch_if.master     nak,
    ctrl_dispatch_if.master     ack,
    ctrl_dispatch_if.master     ack2,
    ctrl_dispatch_if.master     misc,
    output logic [CNT_W-1:0]    nak_cnt,
    output logic [CNT_W-1:0]    ack_cnt,
    output logic [CNT_W-1:0]    ack2_cnt,
    output logic [CNT_W-1:0]    misc_cnt,
    output logic [CNT_W-1:0]    drop_cnt
);

    state_e                state_r;
    route_e                route_r;
    route_e                hdr_route_s;
    route_e                sel_route_s;
    logic                  sel_ready_s;
    logic                  accept_s;
    logic [N_ROUTES-1:0]   cnt_inc_s;

    // Route for the current beat: decoded live in HDR, latched otherwise.
    always_comb begin
        hdr_route_s = decode_route(ctrl.tdata, ctrl.tkeep, ctrl.tlast);
        if (state_r == S_HDR) begin
            sel_route_s = hdr_route_s;
        end else begin
            sel_route_s = route_r;
        end
    end

    // Zero-latency datapath fan-out and ready back-pressure from the selected port.
    always_comb begin
        nak.tdata   = ctrl.tdata;
        nak.tkeep   = ctrl.tkeep;
        nak.tlast   = ctrl.tlast;
        ack.tdata   = ctrl.tdata;
        ack.tkeep   = ctrl.tkeep;
        ack.tlast   = ctrl.tlast;
        ack2.tdata  = ctrl.tdata;
        ack2.tkeep  = ctrl.tkeep;
        ack2.tlast  = ctrl.tlast;
        misc.tdata  = ctrl.tdata;
        misc.tkeep  = ctrl.tkeep;
        misc.tlast  = ctrl.tlast;
        nak.tvalid  = 1'b0;
        ack.tvalid  = 1'b0;
        ack2.tvalid = 1'b0;
        misc.tvalid = 1'b0;
        sel_ready_s = 1'b1;
        case (sel_route_s)
            R_NAK: begin
                nak.tvalid  = ctrl.tvalid & ~core_rst;
                sel_ready_s = nak.tready;
            end
            R_ACK: begin
                ack.tvalid  = ctrl.tvalid & ~core_rst;
                sel_ready_s = ack.tready;
            end
            R_ACK2: begin
                ack2.tvalid = ctrl.tvalid & ~core_rst;
                sel_ready_s = ack2.tready;
            end
            R_MISC: begin
                misc.tvalid = ctrl.tvalid & ~core_rst;
                sel_ready_s = misc.tready;
            end
            R_DROP: begin
                sel_ready_s = 1'b1;
            end
            default: begin
                sel_ready_s = 1'b1;
            end
        endcase
        if (core_rst) begin
            ctrl.tready = 1'b0;
        end else begin
            ctrl.tready = sel_ready_s;
        end
    end

    // Per-route counter strobes on the accepted last beat of a packet.
    always_comb begin
        accept_s  = ctrl.tvalid & ctrl.tready;
        cnt_inc_s = '0;
        if (accept_s && ctrl.tlast) begin
            cnt_inc_s[sel_route_s] = 1'b1;
        end else begin
            cnt_inc_s = '0;
        end
    end

    // Packet framing FSM and route latch.
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            state_r <= S_HDR;
            route_r <= R_MISC;
        end else if (accept_s) begin
            case (state_r)
                S_HDR: begin
                    route_r <= hdr_route_s;
                    if (ctrl.tlast) begin
                        state_r <= S_HDR;
                    end else if (hdr_route_s == R_DROP) begin
                        state_r <= S_DROP;
                    end else begin
                        state_r <= S_FWD;
                    end
                end
                S_FWD, S_DROP: begin
                    if (ctrl.tlast) begin
                        state_r <= S_HDR;
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r <= S_HDR;
                end
            endcase
        end else begin
            state_r <= state_r;
            route_r <= route_r;
        end
    end

    // One wrapping statistics counter per route, indexed by route_e value.
    for (genvar gi = 0; gi < N_ROUTES; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_r;

        // Count completed packets on this route.
        always_ff @(posedge core_clk or posedge core_rst) begin
            if (core_rst) begin
                cnt_r <= '0;
            end else if (cnt_inc_s[gi]) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign nak_cnt  = g_cnt[0].cnt_r;
    assign ack_cnt  = g_cnt[1].cnt_r;
    assign ack2_cnt = g_cnt[2].cnt_r;
    assign misc_cnt = g_cnt[3].cnt_r;
    assign drop_cnt = g_cnt[4].cnt_r;

endmodule

// File: tb/tb_ctrl_dispatch.sv
// Directed self-checking bench for ctrl_dispatch (CNT_W=4 so wrap is reachable).
module tb_ctrl_dispatch;

    localparam int CW = 4;

    logic          core_clk;
    logic          core_rst;
    logic [CW-1:0] nak_cnt, ack_cnt, ack2_cnt, misc_cnt, drop_cnt;
    int            errors;
    int            checks;

    ctrl_dispatch_if ctrl_if ();
    ctrl_dispatch_if nak_if ();
    ctrl_dispatch_if ack_if ();
    ctrl_dispatch_if ack2_if ();
    ctrl_dispatch_if misc_if ();

    ctrl_dispatch #(.CNT_W(CW)) dut (
        .core_clk (core_clk),
        .core_rst (core_rst),
        .ctrl     (ctrl_if),
        .nak      (nak_if),
        .ack      (ack_if),
        .ack2     (ack2_if),
        .misc     (misc_if),
        .nak_cnt  (nak_cnt),
        .ack_cnt  (ack_cnt),
        .ack2_cnt (ack2_cnt),
        .misc_cnt (misc_cnt),
        .drop_cnt (drop_cnt)
    );

    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    function automatic logic [3:0] valids();
        return {nak_if.tvalid, ack_if.tvalid, ack2_if.tvalid, misc_if.tvalid};
    endfunction

    function automatic logic [19:0] counts();
        return {nak_cnt, ack_cnt, ack2_cnt, misc_cnt, drop_cnt};
    endfunction

    task automatic tick();
        @(posedge core_clk);
        @(negedge core_clk);
    endtask

    task automatic drive(input logic [63:0] d, input logic [7:0] k, input logic l);
        ctrl_if.tvalid = 1'b1;
        ctrl_if.tdata  = d;
        ctrl_if.tkeep  = k;
        ctrl_if.tlast  = l;
    endtask

    task automatic idle();
        ctrl_if.tvalid = 1'b0;
        ctrl_if.tlast  = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        nak_if.tready  = 1'b1;
        ack_if.tready  = 1'b1;
        ack2_if.tready = 1'b1;
        misc_if.tready = 1'b1;
        core_rst = 1'b1;
        tick();
        tick();
        core_rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        core_rst = 1'b1;
        drive(64'h8003_0000_0000_0001, 8'hFF, 1'b0);
        #1;
        checks++;
        if (ctrl_if.tready !== 1'b0) begin
            errors++; $display("FAIL reset_tready got=%b exp=0", ctrl_if.tready);
        end
        checks++;
        if (valids() !== 4'b0000) begin
            errors++; $display("FAIL reset_valids got=%b exp=0000", valids());
        end
        checks++;
        if (counts() !== 20'h0) begin
            errors++; $display("FAIL reset_counts got=%h exp=00000", counts());
        end
        tick();
        core_rst = 1'b0;
        idle();
        tick();
    endtask

    task automatic test_nak();
        logic [63:0] beats [3];
        beats[0] = 64'h8003_0000_0000_0001;
        beats[1] = 64'h0000_0000_0000_0002;
        beats[2] = 64'h1234_5678_9ABC_DEF0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(beats[i], 8'hFF, (i == 2));
            #1;
            checks++;
            if (valids() !== 4'b1000 || nak_if.tdata !== beats[i] || ctrl_if.tready !== 1'b1) begin
                errors++;
                $display("FAIL nak_beat%0d valids=%b exp=1000 data=%h exp=%h rdy=%b exp=1",
                         i, valids(), nak_if.tdata, beats[i], ctrl_if.tready);
            end
            tick();
        end
        idle();
        #1;
        checks++;
        if (counts() !== 20'h10000) begin
            errors++; $display("FAIL nak_cnt got=%h exp=10000", counts());
        end
    endtask

    task automatic test_ack_stall();
        logic [63:0] beats [4];
        beats[0] = 64'h8002_0000_0000_00A0;
        beats[1] = 64'hDEAD_BEEF_0000_00A1;
        beats[2] = 64'h0000_0000_0000_00A2;
        beats[3] = 64'h0000_0000_0000_00A3;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(beats[i], 8'hFF, (i == 3));
            if (i == 1) begin
                ack_if.tready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    #1;
                    checks++;
                    if (ctrl_if.tready !== 1'b0 || valids() !== 4'b0100 || ack_if.tdata !== beats[1]) begin
                        errors++;
                        $display("FAIL ack_stall c%0d rdy=%b exp=0 valids=%b exp=0100 data=%h exp=%h",
                                 c, ctrl_if.tready, valids(), ack_if.tdata, beats[1]);
                    end
                    tick();
                end
                ack_if.tready = 1'b1;
            end
            #1;
            checks++;
            if (valids() !== 4'b0100 || ack_if.tdata !== beats[i] || ctrl_if.tready !== 1'b1) begin
                errors++;
                $display("FAIL ack_beat%0d valids=%b exp=0100 data=%h exp=%h rdy=%b exp=1",
                         i, valids(), ack_if.tdata, beats[i], ctrl_if.tready);
            end
            tick();
        end
        idle();
        #1;
        checks++;
        if (counts() !== 20'h01000) begin
            errors++; $display("FAIL ack_cnt got=%h exp=01000", counts());
        end
    endtask

    task automatic test_drop();
        do_reset();
        nak_if.tready  = 1'b0;
        ack_if.tready  = 1'b0;
        ack2_if.tready = 1'b0;
        misc_if.tready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive((i == 0) ? 64'h0003_0000_0000_0000 : 64'h8003_0000_0000_0000, 8'hFF, (i == 1));
            #1;
            checks++;
            if (valids() !== 4'b0000 || ctrl_if.tready !== 1'b1) begin
                errors++;
                $display("FAIL drop_beat%0d valids=%b exp=0000 rdy=%b exp=1", i, valids(), ctrl_if.tready);
            end
            tick();
        end
        idle();
        #1;
        checks++;
        if (counts() !== 20'h00001) begin
            errors++; $display("FAIL drop_cnt got=%h exp=00001", counts());
        end
    endtask

    task automatic test_runt();
        do_reset();
        drive(64'h8003_0000_0000_0000, 8'hFF, 1'b1);
        #1;
        checks++;
        if (valids() !== 4'b0000 || ctrl_if.tready !== 1'b1) begin
            errors++; $display("FAIL runt valids=%b exp=0000 rdy=%b exp=1", valids(), ctrl_if.tready);
        end
        tick();
        drive(64'h8003_0000_0000_0011, 8'h0F, 1'b0);
        #1;
        checks++;
        if (valids() !== 4'b0000) begin
            errors++; $display("FAIL short_keep valids=%b exp=0000", valids());
        end
        tick();
        drive(64'h0000_0000_0000_0012, 8'hFF, 1'b1);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(64'h8003_0000_0000_0020 + 64'(i), 8'hFF, (i == 1));
            #1;
            checks++;
            if (valids() !== 4'b1000) begin
                errors++; $display("FAIL post_runt_nak%0d valids=%b exp=1000", i, valids());
            end
            tick();
        end
        idle();
        #1;
        checks++;
        if (counts() !== 20'h10002) begin
            errors++; $display("FAIL runt_cnts got=%h exp=10002", counts());
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] beats [4];
        logic [3:0]  exp_v [4];
        beats[0] = 64'h8005_0000_0000_0000; exp_v[0] = 4'b0001;
        beats[1] = 64'h0000_0000_0000_0001; exp_v[1] = 4'b0001;
        beats[2] = 64'h8006_0000_0000_0000; exp_v[2] = 4'b0010;
        beats[3] = 64'h0000_0000_0000_0003; exp_v[3] = 4'b0010;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(beats[i], 8'hFF, (i == 1) || (i == 3));
            #1;
            checks++;
            if (valids() !== exp_v[i] || ctrl_if.tready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_beat%0d valids=%b exp=%b rdy=%b exp=1", i, valids(), exp_v[i], ctrl_if.tready);
            end
            tick();
        end
        idle();
        #1;
        checks++;
        if (counts() !== 20'h00110) begin
            errors++; $display("FAIL b2b_cnts got=%h exp=00110", counts());
        end
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        for (int p = 0; p < 17; p++) begin
            drive(64'h8003_0000_0000_0000, 8'hFF, 1'b0);
            tick();
            drive(64'h0000_0000_0000_0000 + 64'(p), 8'hFF, 1'b1);
            tick();
        end
        idle();
        #1;
        checks++;
        if (nak_cnt !== 4'd1) begin
            errors++; $display("FAIL nak_wrap got=%0d exp=1", nak_cnt);
        end
        drive(64'h8002_0000_0000_0000, 8'hFF, 1'b0);
        tick();
        drive(64'h8003_0000_0000_0000, 8'hFF, 1'b0);
        tick();
        drive(64'h8002_0000_0000_0055, 8'hFF, 1'b0);
        core_rst = 1'b1;
        #1;
        checks++;
        if (counts() !== 20'h0 || ctrl_if.tready !== 1'b0 || valids() !== 4'b0000) begin
            errors++;
            $display("FAIL midpkt_reset cnts=%h exp=00000 rdy=%b exp=0 valids=%b exp=0000",
                     counts(), ctrl_if.tready, valids());
        end
        tick();
        core_rst = 1'b0;
        drive(64'h8003_0000_0000_0066, 8'hFF, 1'b0);
        #1;
        checks++;
        if (valids() !== 4'b1000 || ctrl_if.tready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_hdr valids=%b exp=1000 rdy=%b exp=1", valids(), ctrl_if.tready);
        end
        tick();
        drive(64'h8002_0000_0000_0067, 8'hFF, 1'b1);
        #1;
        checks++;
        if (valids() !== 4'b1000) begin
            errors++; $display("FAIL post_reset_body valids=%b exp=1000", valids());
        end
        tick();
        idle();
        #1;
        checks++;
        if (counts() !== 20'h10000) begin
            errors++; $display("FAIL post_reset_cnts got=%h exp=10000", counts());
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        core_rst = 1'b1;
        ctrl_if.tdata = 64'h0;
        ctrl_if.tkeep = 8'h0;
        idle();
        @(negedge core_clk);
        test_reset();
        test_nak();
        test_ack_stall();
        test_drop();
        test_runt();
        test_back_to_back();
        test_wrap_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ctrl_dispatch.md
CTRL_DISPATCH -- requirements
Module: ctrl_dispatch

Interface
REQ-001 Parameter CNT_W, default 16, width of each statistics counter.
REQ-002 core_clk  input  1  core module clock; all logic on its rising edge.
REQ-003 core_rst  input  1  asynchronous, active-high reset.
REQ-004 CTRL_tdata/tkeep/tvalid/tlast  input  64/8/1/1  inbound UDT control-packet stream.
REQ-005 CTRL_tready  output  1  inbound ready.
REQ-006 NAK_tdata/tkeep/tvalid/tlast  output  64/8/1/1  NAK packets to the NAK processing stage.
REQ-007 NAK_tready  input  1  NAK stage ready.
REQ-008 ACK_*, ACK2_*, MISC_*  same widths and directions as NAK_*  ACK, ACK2 and all other valid control packets.
REQ-009 nak_cnt, ack_cnt, ack2_cnt, misc_cnt, drop_cnt  output  CNT_W each  packets forwarded per port and packets dropped.

Function
REQ-010 Beat 0 is the first beat of a packet: the first accepted beat after reset or after a tlast beat.
REQ-011 Beat 0 byte order is network order; tdata[63] SHALL be the control flag and tdata[62:48] the 15-bit type.
REQ-012 Route decode on beat 0:
  - type 3 -> NAK
  - type 2 -> ACK
  - type 6 -> ACK2
  - any other type -> MISC
  - DROP when tdata[63]=0, or tlast=1 on beat 0 (runt: header below 16 bytes), or tkeep!=8'hFF on beat 0.
REQ-013 FSM states: HDR, FWD, DROP.
  - HDR: route decoded combinationally from CTRL_tdata.
  - HDR -> FWD on an accepted non-DROP beat 0 with tlast=0.
  - HDR -> DROP on an accepted DROP beat 0 with tlast=0.
  - FWD/DROP -> HDR on an accepted tlast beat.
  - A runt (tlast on beat 0) SHALL be consumed in HDR and stay in HDR.
REQ-014 Route register latched on the accepted beat 0; it selects the output for all later beats of the packet.
REQ-015 Datapath zero latency: the selected output's tdata/tkeep/tlast equal CTRL_* in the same cycle; selected tvalid = CTRL_tvalid; all other outputs' tvalid = 0.
REQ-016 CTRL_tready = selected output's tready in HDR (non-DROP route) and in FWD; CTRL_tready = 1 in DROP and for any DROP-decoded beat 0.
REQ-017 A beat is accepted when CTRL_tvalid and CTRL_tready are both 1; an output SHALL never assert tvalid for a dropped packet.
REQ-018 AXI-stream rule: once an output asserts tvalid, its data SHALL stay stable until accepted, since CTRL_tvalid/tdata hold while CTRL_tready=0.
REQ-019 Counters increment by 1 on an accepted tlast beat of a packet on their route; drop_cnt also increments on runts.
REQ-020 Counters wrap from 2^CNT_W-1 to 0 without saturating.
REQ-021 Unused output tdata/tkeep/tlast are don't-care; verification checks only the tvalid-qualified port.

Reset
REQ-022 Reset asserted: FSM = HDR, route = MISC, all counters = 0, all output tvalid = 0.
REQ-023 CTRL_tready while in reset = 0.
REQ-024 Reset mid-packet abandons the packet; the next accepted beat after deassertion is treated as beat 0.

Structure
REQ-025 Shared package udt_pkg holds:
  - control type constants (CT_ACK=2, CT_NAK=3, CT_ACK2=6);
  - the route enum {R_NAK, R_ACK, R_ACK2, R_MISC, R_DROP};
  - the FSM state enum.
REQ-026 Single module, no sub-modules; counters are a generate loop inside it.

Verification
REQ-027 NAK of 3 beats, beat 0 tdata=64'h8003_0000_0000_0001, NAK_tready=1 -> 3 beats on NAK only, same cycles, nak_cnt=1.
REQ-028 ACK of 4 beats with ACK_tready low for 5 cycles on beat 1 -> CTRL_tready low for those cycles, ACK data held stable, ack_cnt=1, other tvalids stay 0.
REQ-029 Data packet, beat 0 tdata[63]=0, 2 beats -> no output tvalid, both beats accepted back-to-back, drop_cnt=1.
REQ-030 Single-beat type 3 packet (tlast on beat 0) -> dropped, drop_cnt=1, FSM in HDR; the following NAK is routed normally.
REQ-031 Type 5 then type 6 back-to-back -> MISC then ACK2 with no idle cycle; misc_cnt=1, ack2_cnt=1.
REQ-032 CNT_W=4, 17 NAKs -> nak_cnt wraps to 1; core_rst mid-packet -> all counters 0, next beat decoded as header.
